descriptor_output_arbiter: RTL
==============================

# descriptor_output_arbiter

Parametrised successor of the single TS/NTS descriptor output stage in the time-sensitive injection control path. It arbitrates one time-sensitive (TS) descriptor source and CH_NUM non-time-sensitive (NTS) sources onto one descriptor output toward the input queue. TS has strict priority, and NTS channels are served round-robin. Every source receives an explicit one-cycle ack. An optional starvation guard bounds NTS waiting time under continuous TS load.

## Interface
- CH_NUM, 4: number of NTS channels, 1..16.
- DW, 40: descriptor width (tsntag + bufid).
- STARVE_MAX, 8: consecutive TS grants tolerated while NTS is pending. Used only with the guard compiled in.
- SW, derived: $clog2(CH_NUM+1), source-id width.
- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- iv_ts_descriptor  in  DW  TS descriptor; held stable while i_ts_descriptor_wr=1.
- i_ts_descriptor_wr  in  1  TS request; held until acked.
- o_ts_descriptor_ack  out  1  one-cycle TS capture pulse.
- iv_nts_descriptor  in  CH_NUM*DW  NTS descriptors; channel k occupies bits [k*DW +: DW].
- iv_nts_descriptor_wr  in  CH_NUM  NTS requests; each held until acked.
- ov_nts_descriptor_ack  out  CH_NUM  one-hot, one-cycle NTS capture pulse.
- ov_descriptor  out  DW  captured descriptor toward the input queue.
- o_descriptor_wr  out  1  descriptor valid; held until i_descriptor_ack.
- i_descriptor_ack  in  1  downstream accept pulse.
- ov_descriptor_src  out  SW  source of the current descriptor: 0 = TS, k+1 = NTS channel k.

## Operation
- The FSM has two states.
- IDLE_S:
  - Samples all requests and selects at most one winner.
  - The winner's descriptor is registered into ov_descriptor. o_descriptor_wr=1, ov_descriptor_src is set, the winner's ack pulses, and the next state is WAIT_ACK_S.
  - With no request, outputs stay cleared and the state remains IDLE_S.
- WAIT_ACK_S:
  - Holds ov_descriptor, o_descriptor_wr and ov_descriptor_src unchanged.
  - On i_descriptor_ack: clears ov_descriptor, o_descriptor_wr and ov_descriptor_src to 0 and returns to IDLE_S.
- Selection:
  - TS wins whenever i_ts_descriptor_wr=1, unless the starvation guard overrides.
  - Otherwise the winner is the first requesting NTS channel searched upward from rr_ptr, modulo CH_NUM.
  - After an NTS grant to channel k, rr_ptr becomes (k+1) mod CH_NUM. TS grants leave rr_ptr unchanged.
- Source handshake:
  - A source drops wr in the cycle after its ack pulse.
  - Because the FSM leaves IDLE_S after a grant, a stale wr in the ack cycle is never re-sampled.
- i_descriptor_ack in IDLE_S is ignored.
- ov_descriptor is zero whenever o_descriptor_wr=0.
- Reset values: all outputs 0, state IDLE_S, rr_ptr 0, starvation counter 0.
- Reset mid-operation:
  - The captured descriptor is discarded and no ack is reissued.
  - The upstream owner of that source is responsible for the re-send. This block guarantees only that no partial output is emitted.

## Timing
- Grant latency: request sampled in IDLE_S at cycle t; o_descriptor_wr=1 and the source ack pulse both appear at t+1.
- Downstream ack is legal from t+1 onward. If i_descriptor_ack=1 at cycle a, o_descriptor_wr=0 at a+1 (state IDLE_S).
- The next grant is decided at a+1 and output at a+2. Minimum spacing between descriptors is ack latency + 2 cycles.
- Simultaneous TS and NTS requests: TS wins. The NTS channel keeps wr asserted and is served at the next IDLE_S in which no TS request wins.
- rr_ptr wrap: a grant to channel CH_NUM-1 sets rr_ptr to 0.

## Configuration
- DESC_ARB_STARVE_GUARD_EN defined:
  - starve_cnt (width $clog2(STARVE_MAX+1)) increments on each TS grant made while any NTS wr is pending.
  - It clears on any NTS grant, and on a TS grant with no NTS pending.
  - When starve_cnt==STARVE_MAX and NTS is pending, the round-robin NTS winner is granted over TS.
- Undefined: pure strict TS priority. starve_cnt is absent and STARVE_MAX is unused.

## Structure
- A shared package/header descriptor_pkg holds:
  - the state localparams IDLE_S and WAIT_ACK_S;
  - the source-id encoding SRC_TS=0 and SRC_NTS_BASE=1;
  - the default descriptor width of 40.
- One sub-module, descriptor_rr_pick:
  - combinational rotate-priority encoder over CH_NUM requests and rr_ptr;
  - outputs a valid flag and the winning index.
- The top level holds the FSM, the registers, rr_ptr and the starvation counter.

## Test plan
Configuration for all scenarios: CH_NUM=4, DW=40, STARVE_MAX=2.
- TS alone: iv_ts_descriptor=40'h00_1234_5678 with wr at t, ack at t+3 → o_descriptor_wr high t+1..t+3, o_ts_descriptor_ack pulse at t+1, ov_descriptor_src=0, outputs zero at t+4.
- Round-robin: NTS ch0..ch3 all requesting, immediate acks → grant order 0,1,2,3,0. ov_descriptor_src sequence 1,2,3,4,1. rr_ptr wraps to 0 after the ch3 grant.
- TS and NTS ch2 requesting in the same IDLE_S cycle → TS granted first; ch2 granted at the next IDLE_S; ov_nts_descriptor_ack=4'b0100 only once.
- Guard enabled, TS continuously requesting, ch1 pending → two TS grants, then ch1 granted third, then TS again. Guard disabled → ch1 is never granted while TS is asserted.
- Downstream ack withheld 20 cycles → ov_descriptor stable; no further source acks; i_descriptor_ack pulse in IDLE_S has no effect.
- i_rst asserted during WAIT_ACK_S → all outputs 0 immediately. After release, a still-held NTS ch3 request is re-granted with rr_ptr=0 search order.

Source files
------------

// File: rtl/descriptor_pkg.sv
// Shared constants and types for the TS/NTS descriptor output arbiter.
// The optional starvation guard is enabled with DESC_ARB_STARVE_GUARD_EN.
package descriptor_pkg;

    typedef enum logic [0:0] {
        IDLE_S     = 1'b0,
        WAIT_ACK_S = 1'b1
    } state_t;

    localparam int SRC_TS          = 0;
    localparam int SRC_NTS_BASE    = 1;
    localparam int DESC_DW_DEFAULT = 40;

    function automatic int unsigned src_width(input int unsigned ch_num);
        return $clog2(ch_num + 1);
    endfunction

endpackage

// File: rtl/descriptor_output_arbiter_if.sv
// Bundle of the TS/NTS request side and the descriptor output side of the arbiter.
// master = arbiter, slave = environment (sources and input queue).
interface descriptor_output_arbiter_if #(
    parameter int CH_NUM = 4,
    parameter int DW     = 40,
    parameter int SW     = $clog2(CH_NUM + 1)
);
    logic [DW-1:0]        iv_ts_descriptor;
    logic                 i_ts_descriptor_wr;
    logic                 o_ts_descriptor_ack;
    logic [CH_NUM*DW-1:0] iv_nts_descriptor;
    logic [CH_NUM-1:0]    iv_nts_descriptor_wr;
    logic [CH_NUM-1:0]    ov_nts_descriptor_ack;
    logic [DW-1:0]        ov_descriptor;
    logic                 o_descriptor_wr;
    logic                 i_descriptor_ack;
    logic [SW-1:0]        ov_descriptor_src;

    modport master (
        input  iv_ts_descriptor,
        input  i_ts_descriptor_wr,
        output o_ts_descriptor_ack,
        input  iv_nts_descriptor,
        input  iv_nts_descriptor_wr,
        output ov_nts_descriptor_ack,
        output ov_descriptor,
        output o_descriptor_wr,
        input  i_descriptor_ack,
        output ov_descriptor_src
    );

    modport slave (
        output iv_ts_descriptor,
        output i_ts_descriptor_wr,
        input  o_ts_descriptor_ack,
        output iv_nts_descriptor,
        output iv_nts_descriptor_wr,
        input  ov_nts_descriptor_ack,
        input  ov_descriptor,
        input  o_descriptor_wr,
        output i_descriptor_ack,
        input  ov_descriptor_src
    );
endinterface

// File: rtl/descriptor_rr_pick.sv
// Combinational rotate-priority encoder: first requesting channel at or above
// rr_ptr, wrapping modulo CH_NUM. rr_ptr is expected to be below CH_NUM.
module descriptor_rr_pick #(
    parameter int CH_NUM = 4,
    parameter int PW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    output logic              valid,
    output logic [PW-1:0]     idx
);
    logic [PW:0]       sum  [CH_NUM];
    logic [PW-1:0]     cand [CH_NUM];
    logic [CH_NUM-1:0] hit;

    // cand[gi] is the channel visited at search offset gi
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, rr_ptr} + (PW+1)'(gi);
            assign cand[gi] = (sum[gi] >= (PW+1)'(CH_NUM))
                              ? PW'(sum[gi] - (PW+1)'(CH_NUM))
                              : sum[gi][PW-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from the far end so the smallest offset wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid = 1'b1;
                idx   = cand[i];
            end
        end
    end
endmodule

// File: rtl/descriptor_output_arbiter.sv
// Arbitrates one strict-priority TS source and CH_NUM round-robin NTS sources onto
// one descriptor output. DESC_ARB_STARVE_GUARD_EN bounds NTS waiting under TS load.
module descriptor_output_arbiter
    import descriptor_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DW         = DESC_DW_DEFAULT,
    parameter int STARVE_MAX = 8,
    parameter int SW         = $clog2(CH_NUM + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    descriptor_output_arbiter_if.master  bus
);
    localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    state_t            state_reg;
    logic [PW-1:0]     rr_ptr_reg;
    logic [DW-1:0]     desc_reg;
    logic              wr_reg;
    logic [SW-1:0]     src_reg;
    logic              ts_ack_reg;
    logic [CH_NUM-1:0] nts_ack_reg;

    logic              nts_valid;
    logic [PW-1:0]     nts_idx;
    logic [DW-1:0]     nts_desc_sel;
    logic              starve_force;
    logic              ts_win;

    descriptor_rr_pick #(
        .CH_NUM (CH_NUM),
        .PW     (PW)
    ) u_rr_pick (
        .req    (bus.iv_nts_descriptor_wr),
        .rr_ptr (rr_ptr_reg),
        .valid  (nts_valid),
        .idx    (nts_idx)
    );

    always_comb begin
        nts_desc_sel = bus.iv_nts_descriptor[int'(nts_idx)*DW +: DW];
    end

`ifdef DESC_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt_reg;

    assign starve_force = nts_valid && (starve_cnt_reg == CW'(STARVE_MAX));

    // Counts TS grants that bypassed a pending NTS request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == IDLE_S) begin
            if (ts_win) begin
                starve_cnt_reg <= nts_valid ? starve_cnt_reg + 1'b1 : '0;
            end else if (nts_valid) begin
                starve_cnt_reg <= '0;
            end
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    assign ts_win = bus.i_ts_descriptor_wr && !starve_force;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE_S;
            rr_ptr_reg  <= '0;
            desc_reg    <= '0;
            wr_reg      <= 1'b0;
            src_reg     <= '0;
            ts_ack_reg  <= 1'b0;
            nts_ack_reg <= '0;
        end else begin
            ts_ack_reg  <= 1'b0;
            nts_ack_reg <= '0;
            case (state_reg)
                IDLE_S: begin
                    if (ts_win) begin
                        desc_reg   <= bus.iv_ts_descriptor;
                        wr_reg     <= 1'b1;
                        src_reg    <= SW'(SRC_TS);
                        ts_ack_reg <= 1'b1;
                        state_reg  <= WAIT_ACK_S;
                    end else if (nts_valid) begin
                        desc_reg    <= nts_desc_sel;
                        wr_reg      <= 1'b1;
                        src_reg     <= SW'(nts_idx) + SW'(SRC_NTS_BASE);
                        nts_ack_reg <= CH_NUM'(1) << nts_idx;
                        rr_ptr_reg  <= (nts_idx == PW'(CH_NUM - 1)) ? '0 : nts_idx + 1'b1;
                        state_reg   <= WAIT_ACK_S;
                    end
                end
                WAIT_ACK_S: begin
                    // Stale source wr lines are not looked at while waiting here
                    if (bus.i_descriptor_ack) begin
                        desc_reg  <= '0;
                        wr_reg    <= 1'b0;
                        src_reg   <= '0;
                        state_reg <= IDLE_S;
                    end
                end
                default: state_reg <= IDLE_S;
            endcase
        end
    end

    assign bus.ov_descriptor         = desc_reg;
    assign bus.o_descriptor_wr       = wr_reg;
    assign bus.ov_descriptor_src     = src_reg;
    assign bus.o_ts_descriptor_ack   = ts_ack_reg;
    assign bus.ov_nts_descriptor_ack = nts_ack_reg;
endmodule
